// File: rtl/proc_op_sequencer_pkg.sv
// Shared types for the queued processor op sequencer.
package proc_op_sequencer_pkg;

    localparam int unsigned CMD_DW = 8;
    localparam int unsigned CMD_AW = 12;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_XOR   = 3'd4,
        OP_MUL   = 3'd5,
        OP_LOAD  = 3'd6,
        OP_STORE = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        RW_IDLE  = 2'b00,
        RW_READ  = 2'b10,
        RW_WRITE = 2'b01
    } rw_t;

    // Command FIFO entry at the default operand/address widths
    typedef struct packed {
        opcode_e             op;
        logic [CMD_DW-1:0]   a;
        logic [CMD_DW-1:0]   b;
        logic [CMD_AW-1:0]   addr;
        logic [CMD_DW-1:0]   data;
    } cmd_t;

    // True for commands that go out on the cache port
    function automatic logic is_mem_op(input opcode_e op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/proc_op_sequencer_op_fifo.sv
// Synchronous command FIFO; head entry is presented combinationally.
module proc_op_sequencer_op_fifo
    import proc_op_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = cmd_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic pop_i,
    input  T     wdata_i,
    output T     head_c,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = PW + 1;

    T               mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic           full_q;
    logic           empty_q;
    logic           do_push;
    logic           do_pop;

    // A push into a full FIFO is only honoured when a pop frees a slot the same cycle
    always_comb begin
        do_pop  = pop_i && !empty_q;
        do_push = push_i && (!full_q || do_pop);
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer, occupancy and status flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Entry storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_c  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/proc_op_sequencer.sv
// In-order command sequencer: queues ALU/LOAD/STORE commands and completes them one at a time.
module proc_op_sequencer
    import proc_op_sequencer_pkg::*;
#(
    parameter int unsigned DW        = 8,
    parameter int unsigned AW        = 12,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_RETRY = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_op,
    input  opcode_e         op_sel,
    input  logic [DW-1:0]   A,
    input  logic [DW-1:0]   B,
    input  logic [AW-1:0]   address_in,
    input  logic [DW-1:0]   data_in,
    output logic            full,
    output logic            overflow,
    output logic            req,
    input  logic            gnt,
    input  logic            hit,
    output rw_t             rw,
    output logic [AW-1:0]   address_cache,
    output logic [DW-1:0]   wdata_cache,
    input  logic [DW-1:0]   rdata_cache,
    output logic [2*DW-1:0] result,
    output logic            valid,
    output logic            error,
    output logic            end_op
);

    localparam int unsigned RES_W = 2 * DW;
    localparam int unsigned RC_W  = $clog2(MAX_RETRY + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MEM  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Command entry sized from this instance's widths
    typedef struct packed {
        opcode_e         op;
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
    } cmd_w_t;

    cmd_w_t          push_cmd_c;
    cmd_w_t          head_c;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop_c;

    logic [1:0]      state_q,    state_d;
    cmd_w_t          cmd_q,      cmd_d;
    logic [RC_W-1:0] retry_q,    retry_d;
    logic [RES_W-1:0] pend_res_q, pend_res_d;
    logic            pend_ok_q,  pend_ok_d;
    logic            req_q,      req_d;
    rw_t             rw_q,       rw_d;
    logic [AW-1:0]   addr_q,     addr_d;
    logic [DW-1:0]   wdata_q,    wdata_d;
    logic [RES_W-1:0] result_q,  result_d;
    logic            valid_q,    valid_d;
    logic            error_q,    error_d;
    logic            end_op_q,   end_op_d;
    logic            overflow_q, overflow_d;

    assign push_cmd_c = '{op: op_sel, a: A, b: B, addr: address_in, data: data_in};

    proc_op_sequencer_op_fifo #(
        .DEPTH (DEPTH),
        .T     (cmd_w_t)
    ) u_op_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (start_op),
        .pop_i   (pop_c),
        .wdata_i (push_cmd_c),
        .head_c  (head_c),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-state and registered-output decode
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        retry_d    = retry_q;
        pend_res_d = pend_res_q;
        pend_ok_d  = pend_ok_q;
        req_d      = req_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        result_d   = result_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;
        end_op_d   = 1'b0;
        pop_c      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop_c = 1'b1;
                    cmd_d = head_c;
                    if (is_mem_op(head_c.op)) begin
                        state_d = S_MEM;
                        req_d   = 1'b1;
                        rw_d    = (head_c.op == OP_STORE) ? RW_WRITE : RW_READ;
                        addr_d  = head_c.addr;
                        wdata_d = (head_c.op == OP_STORE) ? head_c.data : '0;
                        retry_d = '0;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end

            S_EXEC: begin
                pend_ok_d = 1'b1;
                state_d   = S_DONE;
                case (cmd_q.op)
                    OP_ADD:  pend_res_d = RES_W'(cmd_q.a) + RES_W'(cmd_q.b);
                    OP_SUB:  pend_res_d = RES_W'(cmd_q.a) - RES_W'(cmd_q.b);
                    OP_AND:  pend_res_d = RES_W'(cmd_q.a & cmd_q.b);
                    OP_OR:   pend_res_d = RES_W'(cmd_q.a | cmd_q.b);
                    OP_XOR:  pend_res_d = RES_W'(cmd_q.a ^ cmd_q.b);
                    OP_MUL:  pend_res_d = RES_W'(cmd_q.a) * RES_W'(cmd_q.b);
                    default: pend_res_d = '0;
                endcase
            end

            S_MEM: begin
                if (gnt) begin
                    if (hit) begin
                        pend_ok_d  = 1'b1;
                        pend_res_d = (cmd_q.op == OP_LOAD) ? RES_W'(rdata_cache)
                                                           : RES_W'(cmd_q.data);
                        req_d      = 1'b0;
                        rw_d       = RW_IDLE;
                        state_d    = S_DONE;
                    end else if (retry_q == RC_W'(MAX_RETRY - 1)) begin
                        // This granted miss is the last one allowed
                        pend_ok_d = 1'b0;
                        req_d     = 1'b0;
                        rw_d      = RW_IDLE;
                        state_d   = S_DONE;
                    end else begin
                        retry_d = retry_q + RC_W'(1);
                    end
                end
            end

            S_DONE: begin
                end_op_d = 1'b1;
                valid_d  = pend_ok_q;
                error_d  = !pend_ok_q;
                if (pend_ok_q) begin
                    result_d = pend_res_q;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                rw_d    = RW_IDLE;
            end
        endcase

        overflow_d = start_op && fifo_full && !pop_c;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            retry_q    <= '0;
            pend_res_q <= '0;
            pend_ok_q  <= 1'b0;
            req_q      <= 1'b0;
            rw_q       <= RW_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            result_q   <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            end_op_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            retry_q    <= retry_d;
            pend_res_q <= pend_res_d;
            pend_ok_q  <= pend_ok_d;
            req_q      <= req_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
            end_op_q   <= end_op_d;
            overflow_q <= overflow_d;
        end
    end

    assign full          = fifo_full;
    assign overflow      = overflow_q;
    assign req           = req_q;
    assign rw            = rw_q;
    assign address_cache = addr_q;
    assign wdata_cache   = wdata_q;
    assign result        = result_q;
    assign valid         = valid_q;
    assign error         = error_q;
    assign end_op        = end_op_q;

endmodule
